uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 16, receive FIFO entries (power of two, >=2).
REQ-002 SHALL provide parameter OVERSAMPLE, default 16, baud ticks per bit (even, >=4).
REQ-003 SHALL provide parameter DIV_WIDTH, default 16, width of the baud divisor.
REQ-004 SHALL have port list, clock and reset first: clk input 1 system clock; rst input 1 reset, asynchronous, active-high.
REQ-005 SHALL have: divisor_i  input  DIV_WIDTH  clk cycles per baud tick (0 treated as 1).
REQ-006 SHALL have: data_bits_i  input  2  word length, 00=5, 01=6, 10=7, 11=8.
REQ-007 SHALL have: parity_en_i  input  1  parity bit present; parity_even_i  input  1  1=even, 0=odd.
REQ-008 SHALL have: rx_i  input  1  serial line, idle high.
REQ-009 SHALL have: rd_en_i  input  1  pop head entry; rd_data_o  output  8  head data; rd_err_o  output  3  head flags {break, framing, parity}.
REQ-010 SHALL have: empty_o  output 1; full_o  output 1; count_o  output  $clog2(FIFO_DEPTH)+1  occupancy.
REQ-011 SHALL have: thresh_i  input  $clog2(FIFO_DEPTH)+1  irq level (0 disables); overrun_o  output 1 sticky; clr_overrun_i  input 1; irq_o  output 1.

Function
REQ-012 SHALL pass rx_i through a 2-flop synchroniser whose flops reset to 1; all decoding uses the synchronised value.
REQ-013 SHALL pulse an internal tick once every max(divisor_i,1) clk cycles from a free-running down-counter, reloaded on expiry.
REQ-014 SHALL implement FSM IDLE -> START -> DATA -> PARITY (only if enabled) -> STOP -> IDLE.
REQ-015 IDLE SHALL leave on a synchronised 1->0 transition only; a line held low does not re-trigger.
REQ-016 START SHALL sample at tick OVERSAMPLE/2 after entry; sample 1 = glitch, return to IDLE with no push; sample 0 = go to DATA.
REQ-017 SHALL latch data_bits_i, parity_en_i, parity_even_i at start-bit confirmation; changes mid-frame have no effect until the next frame.
REQ-018 DATA, PARITY and STOP SHALL each sample once every OVERSAMPLE ticks (mid-bit); data LSB first, unused upper bits zero.
REQ-019 Parity error SHALL be set when the XOR of data and parity bits is 1 (even) or 0 (odd).
REQ-020 Framing error SHALL be set when the stop sample is 0; break SHALL be set when data, parity (if any) and stop are all 0.
REQ-021 SHALL push {flags, data} in the clk cycle after the stop sample, then return to IDLE; only one stop bit is checked.
REQ-022 FIFO SHALL be first-word-fall-through: rd_data_o/rd_err_o show the head entry combinationally, and are 0 when empty.
REQ-023 rd_en_i while empty SHALL be ignored, with no pointer or count change.
REQ-024 Push while full and no pop SHALL drop the frame and set overrun_o; simultaneous pop and push while full SHALL accept both, with count unchanged.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; count_o ranges 0..FIFO_DEPTH; full_o = (count==FIFO_DEPTH); empty_o = (count==0).
REQ-026 overrun_o SHALL clear on clr_overrun_i unless a new overrun occurs the same cycle, in which case it stays set.
REQ-027 irq_o SHALL be registered: 1 when (thresh_i!=0 and count>=thresh_i) or overrun_o or the head entry has any error flag set.

Reset
REQ-028 rst SHALL asynchronously force: FSM IDLE, baud and bit counters 0, synchroniser 1, pointers and count 0, overrun_o 0, irq_o 0.
REQ-029 Outputs at reset SHALL be empty_o=1, full_o=0, count_o=0, rd_data_o=0, rd_err_o=0.
REQ-030 rst asserted mid-frame SHALL discard the partial frame; after release, no push occurs until a fresh falling edge.

Verification
REQ-031 Frame test: divisor=4, 8N1, send 0xA5 (64 clk/bit) -> one push, rd_data_o=0xA5, rd_err_o=000, count_o=1.
REQ-032 Parity and framing test: 7E1, send 0x41 with parity bit 1 -> rd_err_o=001; then a frame with stop=0 -> rd_err_o bit1=1; an all-zero frame -> 110 (+parity bit per mode).
REQ-033 Glitch test: 1-tick-wide low pulse on rx_i -> no push, FSM back in IDLE, count_o=0.
REQ-034 Overrun test: FIFO_DEPTH=16, send 17 frames with no reads -> count_o=16, full_o=1, overrun_o=1, irq_o=1, 17th frame absent; clr_overrun_i -> overrun_o=0.
REQ-035 Boundary test: pop coincident with push while full -> count stays 16, order preserved across pointer wrap; rd_en_i while empty -> no change.
REQ-036 Reset test: assert rst during the DATA state of a frame -> all reset values of REQ-028/029 hold immediately; no push after release.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver (5..8 data bits, optional even/odd parity, one stop bit)
//   with oversampled mid-bit sampling, feeding a first-word-fall-through
//   receive FIFO that stores {break, framing, parity, data[7:0]} per frame.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   divisor_i         clk cycles per baud tick (0 behaves as 1)
//   data_bits_i       word length: 00=5, 01=6, 10=7, 11=8
//   parity_en_i       parity bit present
//   parity_even_i     1 = even parity, 0 = odd parity
//   rx_i              serial line, idle high (asynchronous)
//   rd_en_i           pop the head entry (ignored while empty)
//   rd_data_o         head data, 0 when empty
//   rd_err_o          head flags {break, framing, parity}, 0 when empty
//   empty_o, full_o   FIFO status
//   count_o           FIFO occupancy, 0..FIFO_DEPTH
//   thresh_i          occupancy interrupt level, 0 disables
//   overrun_o         sticky: a frame was dropped because the FIFO was full
//   clr_overrun_i     clear overrun_o
//   irq_o             registered interrupt request
//   state_o           receiver FSM state (debug/observability)
//
// FIFO handshake: the receiver offers one word per frame as a single-cycle
// push with no back-pressure. rd_en_i is a pop request that is accepted only
// when the FIFO is not empty; a push is accepted when the FIFO is not full or
// when a pop is accepted in the same cycle, otherwise it is dropped and
// overrun_o is set.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DIV_WIDTH-1:0]          divisor_i,
   input  logic [1:0]                    data_bits_i,
   input  logic                          parity_en_i,
   input  logic                          parity_even_i,
   input  logic                          rx_i,
   input  logic                          rd_en_i,
   output logic [7:0]                    rd_data_o,
   output logic [2:0]                    rd_err_o,
   output logic                          empty_o,
   output logic                          full_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   input  logic [$clog2(FIFO_DEPTH):0]   thresh_i,
   output logic                          overrun_o,
   input  logic                          clr_overrun_i,
   output logic                          irq_o,
   output logic [2:0]                    state_o
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0] OS_FULL = OS_W'(OVERSAMPLE - 1);
   localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t state;
   assign state_o = state;

   // -------------------------------------------------------------------------
   // Baud tick generator: free-running down-counter, tick on zero then reload.
   // -------------------------------------------------------------------------
   logic [DIV_WIDTH-1:0] div_cnt;
   logic [DIV_WIDTH-1:0] div_reload;
   logic                 tick;

   assign div_reload = (divisor_i == '0) ? '0 : divisor_i - DIV_WIDTH'(1);
   assign tick       = (div_cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       div_cnt <= '0;
      else if (tick) div_cnt <= div_reload;
      else           div_cnt <= div_cnt - DIV_WIDTH'(1);
   end

   // -------------------------------------------------------------------------
   // Input synchroniser plus one history flop for falling-edge detection.
   // All flops reset to the idle level so reset itself never looks like a
   // start bit.
   // -------------------------------------------------------------------------
   logic rx_s1, rx_s2, rx_d;
   logic fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= rx_i;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   assign fall = rx_d & ~rx_s2;

   // -------------------------------------------------------------------------
   // Receiver FSM
   // -------------------------------------------------------------------------
   logic [OS_W-1:0] os_cnt;
   logic [2:0]      bit_idx;
   logic [2:0]      last_idx;
   logic [7:0]      shreg;
   logic            par_bit;
   logic [1:0]      cfg_bits;
   logic            cfg_par_en;
   logic            cfg_par_even;
   logic            sample;
   logic            pe, fe, brk;
   logic            push_valid;
   logic [10:0]     push_word;

   // START samples half a bit in; every later state samples a full bit on.
   assign sample   = tick & (os_cnt == ((state == ST_START) ? OS_HALF : OS_FULL));
   assign last_idx = 3'd4 + {1'b0, cfg_bits};

   // Flags for the frame being closed by the stop sample (rx_s2 is the stop bit).
   // Odd parity expects the XOR of data and parity to be 1, even expects 0.
   assign pe  = cfg_par_en & ((^shreg) ^ par_bit ^ ~cfg_par_even);
   assign fe  = ~rx_s2;
   assign brk = (shreg == 8'h00) & ~par_bit & ~rx_s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         os_cnt       <= '0;
         bit_idx      <= '0;
         shreg        <= '0;
         par_bit      <= 1'b0;
         cfg_bits     <= '0;
         cfg_par_en   <= 1'b0;
         cfg_par_even <= 1'b0;
         push_valid   <= 1'b0;
         push_word    <= '0;
      end else begin
         push_valid <= 1'b0;
         if (state != ST_IDLE && tick)
            os_cnt <= sample ? '0 : os_cnt + OS_W'(1);
         case (state)
            ST_IDLE: begin
               if (fall) begin
                  state  <= ST_START;
                  os_cnt <= '0;
               end
            end
            ST_START: begin
               if (sample) begin
                  if (rx_s2) begin
                     state <= ST_IDLE;
                  end else begin
                     // Frame format is frozen here for the whole frame.
                     state        <= ST_DATA;
                     cfg_bits     <= data_bits_i;
                     cfg_par_en   <= parity_en_i;
                     cfg_par_even <= parity_even_i;
                     shreg        <= '0;
                     par_bit      <= 1'b0;
                     bit_idx      <= '0;
                  end
               end
            end
            ST_DATA: begin
               if (sample) begin
                  shreg[bit_idx] <= rx_s2;
                  if (bit_idx == last_idx)
                     state <= cfg_par_en ? ST_PARITY : ST_STOP;
                  else
                     bit_idx <= bit_idx + 3'd1;
               end
            end
            ST_PARITY: begin
               if (sample) begin
                  par_bit <= rx_s2;
                  state   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (sample) begin
                  push_valid <= 1'b1;
                  push_word  <= {brk, fe, pe, shreg};
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Receive FIFO (first-word-fall-through)
   // -------------------------------------------------------------------------
   logic [10:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop, wr_ok, ovr_set;
   logic [10:0]   head_word;

   assign empty_o = (count_o == '0);
   assign full_o  = (count_o == DEPTH_C);
   assign pop     = rd_en_i & ~empty_o;
   assign wr_ok   = push_valid & (~full_o | pop);
   assign ovr_set = push_valid & full_o & ~pop;

   assign head_word = mem[rd_ptr];
   assign rd_data_o = empty_o ? 8'h00 : head_word[7:0];
   assign rd_err_o  = empty_o ? 3'b000 : head_word[10:8];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_o   <= '0;
         overrun_o <= 1'b0;
         irq_o     <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, pop})
            2'b10:   count_o <= count_o + CW'(1);
            2'b01:   count_o <= count_o - CW'(1);
            default: count_o <= count_o;
         endcase
         // A fresh overrun wins over a clear in the same cycle.
         if (ovr_set)            overrun_o <= 1'b1;
         else if (clr_overrun_i) overrun_o <= 1'b0;
         irq_o <= ((thresh_i != '0) && (count_o >= thresh_i)) || overrun_o ||
                  (rd_err_o != 3'b000);
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int CW    = 5;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [15:0]   divisor;
   logic [1:0]    data_bits;
   logic          parity_en, parity_even;
   logic          rx, rd_en, clr_overrun;
   logic [CW-1:0] thresh;
   logic [7:0]    rd_data;
   logic [2:0]    rd_err;
   logic          empty, full, overrun, irq;
   logic [CW-1:0] count;
   logic [2:0]    state;

   uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .divisor_i     (divisor),
      .data_bits_i   (data_bits),
      .parity_en_i   (parity_en),
      .parity_even_i (parity_even),
      .rx_i          (rx),
      .rd_en_i       (rd_en),
      .rd_data_o     (rd_data),
      .rd_err_o      (rd_err),
      .empty_o       (empty),
      .full_o        (full),
      .count_o       (count),
      .thresh_i      (thresh),
      .overrun_o     (overrun),
      .clr_overrun_i (clr_overrun),
      .irq_o         (irq),
      .state_o       (state)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // 64 clk per bit with divisor 4 and 16x oversampling.
   task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                             input logic pbit, input logic stop);
      rx = 1'b0;
      idle_clk(64);
      for (int i = 0; i < nbits; i++) begin
         rx = d[i];
         idle_clk(64);
      end
      if (has_par) begin
         rx = pbit;
         idle_clk(64);
      end
      rx = stop;
      idle_clk(64);
      rx = 1'b1;
      idle_clk(32);
   endtask

   task automatic pop1();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_empty"},   empty,   1);
      check({tag, "_full"},    full,    0);
      check({tag, "_count"},   count,   0);
      check({tag, "_rd_data"}, rd_data, 0);
      check({tag, "_rd_err"},  rd_err,  0);
      check({tag, "_overrun"}, overrun, 0);
      check({tag, "_irq"},     irq,     0);
      check({tag, "_state"},   state,   S_IDLE);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      rst = 1'b1; rx = 1'b1; divisor = 16'd4; data_bits = 2'b11;
      parity_en = 1'b0; parity_even = 1'b0; rd_en = 1'b0;
      clr_overrun = 1'b0; thresh = '0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      idle_clk(5);

      // 8N1 frame 0xA5
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      check("a5_count", count, 1);
      check("a5_data", rd_data, 8'hA5);
      check("a5_err", rd_err, 3'b000);
      check("a5_empty", empty, 0);
      check("a5_irq", irq, 0);
      pop1();
      check("a5_pop_count", count, 0);
      check("a5_pop_empty", empty, 1);
      check("a5_pop_data", rd_data, 0);

      // 7E1: 0x41 has two ones, parity bit 1 is wrong
      data_bits = 2'b10; parity_en = 1'b1; parity_even = 1'b1;
      send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
      check("par_data", rd_data, 8'h41);
      check("par_err", rd_err, 3'b001);
      check("par_irq", irq, 1);
      pop1();
      // correct parity, stop bit 0
      send_frame(8'h41, 7, 1'b1, 1'b0, 1'b0);
      check("frm_data", rd_data, 8'h41);
      check("frm_err", rd_err, 3'b010);
      pop1();
      // all-zero frame, even parity bit 0 is correct
      send_frame(8'h00, 7, 1'b1, 1'b0, 1'b0);
      check("brk_data", rd_data, 8'h00);
      check("brk_err", rd_err, 3'b110);
      check("brk_count", count, 1);
      pop1();
      // 5O1: 0x15 has three ones, parity bit 0 is correct for odd
      data_bits = 2'b00; parity_even = 1'b0;
      send_frame(8'h15, 5, 1'b1, 1'b0, 1'b1);
      check("odd5_data", rd_data, 8'h15);
      check("odd5_err", rd_err, 3'b000);
      pop1();
      data_bits = 2'b11; parity_en = 1'b0;

      // glitch: one baud tick (4 clk) low
      rx = 1'b0;
      idle_clk(4);
      rx = 1'b1;
      idle_clk(10);
      check("glitch_start", state, S_START);
      idle_clk(100);
      check("glitch_idle", state, S_IDLE);
      check("glitch_count", count, 0);
      check("glitch_empty", empty, 1);

      // overrun: 17 frames, no reads
      for (int i = 0; i < 17; i++)
         send_frame(8'(8'h10 + i), 8, 1'b0, 1'b0, 1'b1);
      check("ovr_count", count, 16);
      check("ovr_full", full, 1);
      check("ovr_flag", overrun, 1);
      check("ovr_irq", irq, 1);
      check("ovr_head", rd_data, 8'h10);
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      check("ovr_clr", overrun, 0);
      idle_clk(2);
      check("ovr_clr_irq", irq, 0);
      thresh = 5'd16;
      idle_clk(2);
      check("thr16_irq", irq, 1);
      thresh = 5'd17;
      idle_clk(2);
      check("thr17_irq", irq, 0);
      thresh = '0;

      // pop coincident with push while full
      n = 0;
      fork
         send_frame(8'h20, 8, 1'b0, 1'b0, 1'b1);
         begin
            while (state !== S_STOP && n < 2000) begin
               @(negedge clk);
               n++;
            end
            while (state === S_STOP && n < 4000) begin
               @(negedge clk);
               n++;
            end
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
         end
      join
      check("pp_wait", (n < 4000), 1);
      check("pp_count", count, 16);
      check("pp_full", full, 1);
      check("pp_overrun", overrun, 0);
      for (int i = 0; i < 16; i++) begin
         check("pp_order", rd_data, (i < 15) ? (8'h11 + i) : 8'h20);
         pop1();
      end
      check("drain_count", count, 0);
      check("drain_empty", empty, 1);
      pop1();
      check("empty_pop_count", count, 0);
      check("empty_pop_empty", empty, 1);
      check("empty_pop_data", rd_data, 0);
      send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
      check("after_wrap_count", count, 1);
      check("after_wrap_data", rd_data, 8'h33);

      // reset during DATA
      thresh = 5'd1;
      idle_clk(2);
      check("pre_rst_irq", irq, 1);
      rx = 1'b0;
      idle_clk(64);
      idle_clk(64);
      check("pre_rst_state", state, S_DATA);
      rst = 1'b1;
      rx = 1'b1;
      #1;
      check_reset_values("midrst");
      idle_clk(3);
      rst = 1'b0;
      idle_clk(1000);
      check("post_rst_count", count, 0);
      check("post_rst_empty", empty, 1);
      check("post_rst_state", state, S_IDLE);

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
